// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_pkg
// Brief    : Shared encodings and timing helpers for the extended UART receiver.
// Revision : 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE     = 8;
    localparam int PRESCALE_CNT_W = 19;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2,
        PARITY_RSVD = 2'd3
    } parity_mode_e;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP1     = 3'd4,
        RX_STOP2     = 3'd5,
        RX_WAIT_IDLE = 3'd6
    } rx_state_e;

    // A prescale of zero behaves as one so the bit period is never zero.
    function automatic logic [PRESCALE_CNT_W-1:0] bit_period(input logic [15:0] prescale);
        logic [15:0] p;
        p = (prescale == 16'd0) ? 16'd1 : prescale;
        return PRESCALE_CNT_W'(p) * PRESCALE_CNT_W'(OVERSAMPLE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_rx_fifo
// Brief    : Synchronous FIFO whose head word sits in a dedicated output register.
// Revision : 1.0
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             full_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] ring_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [AW:0]      count_q;

    logic w_pop;
    logic w_head_load;
    logic w_ring_wr;
    logic w_ring_rd;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign data_o  = head_q;

    // Total occupancy includes the head register; the ring holds the remainder.
    assign w_pop       = valid_o && ready_i;
    assign w_head_load = push_i && ((count_q == '0) || ((count_q == (AW+1)'(1)) && w_pop));
    assign w_ring_wr   = push_i && !w_head_load;
    assign w_ring_rd   = w_pop && (count_q > (AW+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (w_head_load) begin
                head_q <= data_i;
            end else if (w_ring_rd) begin
                head_q <= ring_q[rd_q];
            end
            if (w_ring_wr) begin
                wr_q <= wr_q + AW'(1);
            end
            if (w_ring_rd) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push_i, w_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_ring_wr) begin
            ring_q[wr_q] <= data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ext.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : uart_rx_ext
// Brief    : AXI4-Stream UART receiver with parity, 1/2 stop bits, voting and
//            break detection. Define UART_RX_FIFO_EN for an output FIFO.
// Revision : 1.0
// ---------------------------------------------------------------------------
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  rxd,
    input  logic [15:0]           prescale,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  break_detect
);

    localparam logic [3:0] C_LAST_BIT = 4'(DATA_WIDTH - 1);

    if ((DATA_WIDTH < 5) || (DATA_WIDTH > 9) || (FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_param
        $error("uart_rx_ext: illegal DATA_WIDTH or FIFO_DEPTH");
    end

    logic                      sync1_q;
    logic                      sync2_q;
    logic [2:0]                hist_q;
    rx_state_e                 state_q;
    logic [PRESCALE_CNT_W-1:0] cnt_q;
    logic [3:0]                bitcnt_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic [15:0]               pre_q;
    parity_mode_e              par_q;
    logic                      two_q;
    logic                      par_bit_q;
    logic                      par_err_q;
    logic                      busy_q;
    logic                      overrun_q;
    logic                      frame_q;
    logic                      parity_q;
    logic                      break_q;

    logic                      w_vote;
    logic                      w_tick;
    logic                      w_par_en;
    logic [PRESCALE_CNT_W-1:0] w_period;
    logic [PRESCALE_CNT_W-1:0] w_half_live;
    logic                      w_complete;
    logic                      w_pop;
    logic                      w_sink_full;
    logic                      w_push;

    assign w_vote      = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    assign w_tick      = (cnt_q == '0);
    assign w_par_en    = (par_q == PARITY_EVEN) || (par_q == PARITY_ODD);
    assign w_period    = bit_period(pre_q);
    assign w_half_live = (bit_period(prescale) >> 1) - PRESCALE_CNT_W'(1);
    assign w_complete  = w_tick && w_vote &&
                         (((state_q == RX_STOP1) && !two_q) || (state_q == RX_STOP2));
    assign w_pop       = m_axis_tvalid && m_axis_tready;
    assign w_push      = w_complete && !par_err_q && !w_sink_full;

    assign busy          = busy_q;
    assign overrun_error = overrun_q;
    assign frame_error   = frame_q;
    assign parity_error  = parity_q;
    assign break_detect  = break_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 3'b111;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            hist_q  <= {hist_q[1:0], sync2_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bitcnt_q  <= '0;
            data_q    <= '0;
            pre_q     <= '0;
            par_q     <= PARITY_NONE;
            two_q     <= 1'b0;
            par_bit_q <= 1'b0;
            par_err_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
            break_q   <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
            parity_q  <= 1'b0;
            break_q   <= 1'b0;
            if (!w_tick) begin
                cnt_q <= cnt_q - PRESCALE_CNT_W'(1);
            end

            case (state_q)
                RX_IDLE: begin
                    if (!sync2_q) begin
                        state_q   <= RX_START;
                        cnt_q     <= w_half_live;
                        pre_q     <= prescale;
                        par_q     <= parity_mode_e'(parity_mode);
                        two_q     <= two_stop;
                        bitcnt_q  <= '0;
                        par_bit_q <= 1'b0;
                        par_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                RX_START: begin
                    if (w_tick) begin
                        if (!w_vote) begin
                            state_q <= RX_DATA;
                            cnt_q   <= w_period - PRESCALE_CNT_W'(1);
                        end else begin
                            state_q <= RX_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                RX_DATA: begin
                    if (w_tick) begin
                        data_q   <= {w_vote, data_q[DATA_WIDTH-1:1]};
                        cnt_q    <= w_period - PRESCALE_CNT_W'(1);
                        bitcnt_q <= bitcnt_q + 4'd1;
                        if (bitcnt_q == C_LAST_BIT) begin
                            state_q <= w_par_en ? RX_PARITY : RX_STOP1;
                        end
                    end
                end
                RX_PARITY: begin
                    if (w_tick) begin
                        par_bit_q <= w_vote;
                        par_err_q <= w_vote ^ (^data_q) ^ (par_q == PARITY_ODD);
                        cnt_q     <= w_period - PRESCALE_CNT_W'(1);
                        state_q   <= RX_STOP1;
                    end
                end
                RX_STOP1: begin
                    if (w_tick) begin
                        if (!w_vote) begin
                            frame_q <= 1'b1;
                            break_q <= (data_q == '0) && !par_bit_q;
                            state_q <= RX_WAIT_IDLE;
                        end else if (two_q) begin
                            cnt_q   <= w_period - PRESCALE_CNT_W'(1);
                            state_q <= RX_STOP2;
                        end
                    end
                end
                RX_STOP2: begin
                    if (w_tick && !w_vote) begin
                        frame_q <= 1'b1;
                        state_q <= RX_WAIT_IDLE;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (sync2_q) begin
                        state_q <= RX_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= RX_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            // Word completion overrides the per-state actions above.
            if (w_complete) begin
                if (par_err_q) begin
                    parity_q <= 1'b1;
                end else if (w_sink_full) begin
                    overrun_q <= 1'b1;
                end
                state_q <= RX_IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_EN
    logic w_fifo_full;

    uart_rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (data_q),
        .ready_i (m_axis_tready),
        .full_o  (w_fifo_full),
        .valid_o (m_axis_tvalid),
        .data_o  (m_axis_tdata)
    );

    assign w_sink_full = w_fifo_full && !w_pop;
`else
    logic                  tvalid_q;
    logic [DATA_WIDTH-1:0] tdata_q;

    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign w_sink_full   = tvalid_q && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
        end else if (w_push) begin
            tvalid_q <= 1'b1;
            tdata_q  <= data_q;
        end else if (m_axis_tready) begin
            tvalid_q <= 1'b0;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_uart_rx_ext
// Brief    : Self-checking bench for uart_rx_ext against a frame-level model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx_ext;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          rxd = 1'b1;
    logic [15:0]   prescale = 16'd2;
    logic [1:0]    parity_mode = 2'd0;
    logic          two_stop = 1'b0;
    logic          busy;
    logic          overrun_error;
    logic          frame_error;
    logic          parity_error;
    logic          break_detect;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q [$];
    int c_frame, c_par, c_ovr, c_brk, c_bad;

    always #5 clk = ~clk;

    uart_rx_ext #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .rxd           (rxd),
        .prescale      (prescale),
        .parity_mode   (parity_mode),
        .two_stop      (two_stop),
        .busy          (busy),
        .overrun_error (overrun_error),
        .frame_error   (frame_error),
        .parity_error  (parity_error),
        .break_detect  (break_detect)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
            c_frame += int'(frame_error);
            c_par   += int'(parity_error);
            c_ovr   += int'(overrun_error);
            c_brk   += int'(break_detect);
            if (break_detect && !frame_error) c_bad++;
            if ((int'(frame_error) + int'(parity_error) + int'(overrun_error)) > 1) c_bad++;
        end
    end

    task automatic clr_mon();
        got_q.delete();
        c_frame = 0; c_par = 0; c_ovr = 0; c_brk = 0; c_bad = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int period_of(input logic [15:0] p);
        return ((p == 16'd0) ? 1 : int'(p)) * 8;
    endfunction

    function automatic logic ref_parity(input logic [7:0] d, input logic [1:0] pm);
        return logic'(($countones(d) % 2) == 1) ^ (pm == 2'd2);
    endfunction

    // 0 word delivered, 1 frame error, 2 frame error with break, 3 parity error
    function automatic int model_outcome(input logic [7:0] d, input logic [1:0] pm, input logic two,
                                         input logic par_ok, input logic s1, input logic s2);
        logic pe;
        logic pbit;
        pe   = (pm == 2'd1) || (pm == 2'd2);
        pbit = ref_parity(d, pm) ^ !par_ok;
        if (!s1) return ((d == 8'h00) && (!pe || !pbit)) ? 2 : 1;
        if (two && !s2) return 1;
        if (pe && !par_ok) return 3;
        return 0;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic two,
                              input logic par_ok, input logic s1, input logic s2, input logic scramble);
        int         t;
        logic       bits [$];
        logic [15:0] saved_pre;
        parity_mode = pm;
        two_stop    = two;
        saved_pre   = prescale;
        t           = period_of(prescale);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if ((pm == 2'd1) || (pm == 2'd2)) bits.push_back(ref_parity(d, pm) ^ !par_ok);
        bits.push_back(s1);
        if (two) bits.push_back(s2);
        for (int i = 0; i < bits.size(); i++) begin
            rxd = bits[i];
            if ((i == 1) && scramble) begin
                prescale    = 16'($urandom);
                parity_mode = 2'($urandom);
                two_stop    = 1'($urandom);
            end
            tick(t);
        end
        rxd         = 1'b1;
        prescale    = saved_pre;
        parity_mode = pm;
        two_stop    = two;
        tick(2 * t);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(5);
        rst = 1'b0;
        tick(1);
        n_checks++; if (m_axis_tvalid !== 1'b0) begin $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); n_fail++; end
        n_checks++; if (m_axis_tdata !== 8'h00) begin $display("FAIL reset_tdata got %h want 00", m_axis_tdata); n_fail++; end
        n_checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); n_fail++; end
        n_checks++; if ({overrun_error, frame_error, parity_error, break_detect} !== 4'b0000) begin
            $display("FAIL reset_errors got %b want 0000", {overrun_error, frame_error, parity_error, break_detect}); n_fail++; end
    endtask

    task automatic test_basic();
        logic [7:0] w;
        prescale = 16'd2;
        clr_mon();
        fork
            send_frame(8'hA5, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
            begin
                tick(48);
                n_checks++; if (busy !== 1'b1) begin $display("FAIL basic_busy_mid got %b want 1", busy); n_fail++; end
            end
        join
        w = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_checks++; if (got_q.size() !== 1) begin $display("FAIL basic_count got %0d want 1", got_q.size()); n_fail++; end
        n_checks++; if (w !== 8'hA5) begin $display("FAIL basic_data got %h want a5", w); n_fail++; end
        n_checks++; if ((c_frame + c_par + c_ovr + c_brk) !== 0) begin $display("FAIL basic_errors got %0d want 0", c_frame + c_par + c_ovr + c_brk); n_fail++; end
        n_checks++; if (busy !== 1'b0) begin $display("FAIL basic_busy_end got %b want 0", busy); n_fail++; end
    endtask

    task automatic test_parity();
        logic [7:0] w;
        clr_mon();
        send_frame(8'h07, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++; if (c_par !== 1) begin $display("FAIL parity_err_pulse got %0d want 1", c_par); n_fail++; end
        n_checks++; if (got_q.size() !== 0) begin $display("FAIL parity_drop got %0d want 0", got_q.size()); n_fail++; end
        send_frame(8'h07, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        w = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_checks++; if (w !== 8'h07) begin $display("FAIL parity_good_data got %h want 07", w); n_fail++; end
        n_checks++; if (c_par !== 1) begin $display("FAIL parity_good_noerr got %0d want 1", c_par); n_fail++; end
    endtask

    task automatic test_two_stop();
        logic [7:0] w;
        clr_mon();
        send_frame(8'h81, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++; if ({c_frame, c_brk} !== {32'd1, 32'd0}) begin $display("FAIL stop2_frame got frame=%0d brk=%0d want 1 0", c_frame, c_brk); n_fail++; end
        n_checks++; if (got_q.size() !== 0) begin $display("FAIL stop2_drop got %0d want 0", got_q.size()); n_fail++; end
        send_frame(8'h3C, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        w = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_checks++; if (w !== 8'h3C) begin $display("FAIL stop2_next got %h want 3c", w); n_fail++; end
        two_stop = 1'b0;
    endtask

    task automatic test_glitch();
        prescale = 16'd2;
        parity_mode = 2'd0;
        clr_mon();
        rxd = 1'b0;
        tick(2);
        rxd = 1'b1;
        tick(16);
        n_checks++; if (busy !== 1'b0) begin $display("FAIL glitch_busy got %b want 0", busy); n_fail++; end
        tick(32);
        n_checks++; if ((got_q.size() + c_frame + c_par + c_ovr + c_brk) !== 0) begin
            $display("FAIL glitch_quiet got words=%0d errs=%0d want 0 0", got_q.size(), c_frame + c_par + c_ovr + c_brk); n_fail++; end
    endtask

    task automatic test_break();
        logic [7:0] w;
        prescale = 16'd2;
        clr_mon();
        rxd = 1'b0;
        tick(3 * 10 * 16);
        rxd = 1'b1;
        tick(32);
        n_checks++; if ({c_frame, c_brk} !== {32'd1, 32'd1}) begin $display("FAIL break_pulses got frame=%0d brk=%0d want 1 1", c_frame, c_brk); n_fail++; end
        send_frame(8'h55, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        w = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_checks++; if (w !== 8'h55) begin $display("FAIL break_next got %h want 55", w); n_fail++; end
    endtask

    task automatic test_overrun();
        logic [15:0] pair;
        clr_mon();
        m_axis_tready = 1'b0;
        send_frame(8'h11, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send_frame(8'h22, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`ifdef UART_RX_FIFO_EN
        n_checks++; if (c_ovr !== 0) begin $display("FAIL ovr_fifo_early got %0d want 0", c_ovr); n_fail++; end
        send_frame(8'h33, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
`endif
        n_checks++; if (c_ovr !== 1) begin $display("FAIL ovr_pulse got %0d want 1", c_ovr); n_fail++; end
        n_checks++; if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'h11}) begin
            $display("FAIL ovr_hold got v=%b d=%h want 1 11", m_axis_tvalid, m_axis_tdata); n_fail++; end
        m_axis_tready = 1'b1;
        tick(4);
`ifdef UART_RX_FIFO_EN
        pair = (got_q.size() == 2) ? {got_q[0], got_q[1]} : 16'hxxxx;
        n_checks++; if (pair !== 16'h1122) begin $display("FAIL ovr_fifo_drain got %h want 1122", pair); n_fail++; end
`else
        pair = (got_q.size() == 1) ? {8'h00, got_q[0]} : 16'hxxxx;
        n_checks++; if (pair !== 16'h0011) begin $display("FAIL ovr_drain got %h want 0011", pair); n_fail++; end
`endif
        n_checks++; if (m_axis_tvalid !== 1'b0) begin $display("FAIL ovr_empty got %b want 0", m_axis_tvalid); n_fail++; end
    endtask

    task automatic test_mid_reset();
        logic [7:0] w;
        clr_mon();
        m_axis_tready = 1'b0;
        send_frame(8'h5A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        rxd = 1'b0;
        tick(40);
        n_checks++; if (busy !== 1'b1) begin $display("FAIL rst_busy_before got %b want 1", busy); n_fail++; end
        rst = 1'b1;
        rxd = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if ({busy, m_axis_tvalid, m_axis_tdata} !== 10'b0) begin
            $display("FAIL rst_mid got busy=%b v=%b d=%h want 0 0 00", busy, m_axis_tvalid, m_axis_tdata); n_fail++; end
        tick(1);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        tick(40);
        n_checks++; if (got_q.size() !== 0) begin $display("FAIL rst_discard got %0d want 0", got_q.size()); n_fail++; end
        send_frame(8'h99, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        w = (got_q.size() > 0) ? got_q[0] : 8'hxx;
        n_checks++; if (w !== 8'h99) begin $display("FAIL rst_next got %h want 99", w); n_fail++; end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [1:0]  pm;
        logic        two, par_ok, s1, s2;
        int          oc;
        logic [47:0] exp_sig, got_sig;
        for (int n = 0; n < 40; n++) begin
            prescale = 16'($urandom_range(0, 3));
            d      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            pm     = 2'($urandom);
            two    = 1'($urandom);
            par_ok = ($urandom_range(0, 5) != 0);
            s1     = ($urandom_range(0, 5) != 0);
            s2     = ($urandom_range(0, 5) != 0);
            oc     = model_outcome(d, pm, two, par_ok, s1, s2);
            exp_sig = {8'((oc == 0) ? 1 : 0), (oc == 0) ? d : 8'h00,
                       8'((oc == 1 || oc == 2) ? 1 : 0), 8'((oc == 2) ? 1 : 0),
                       8'((oc == 3) ? 1 : 0), 8'(0)};
            clr_mon();
            send_frame(d, pm, two, par_ok, s1, s2, 1'b1);
            got_sig = {8'(got_q.size()), (got_q.size() > 0) ? got_q[0] : 8'h00,
                       8'(c_frame), 8'(c_brk), 8'(c_par), 8'(c_ovr)};
            n_checks++; if (got_sig !== exp_sig) begin
                $display("FAIL random_frame%0d d=%h pm=%0d two=%0b got %h want %h", n, d, pm, two, got_sig, exp_sig); n_fail++; end
            n_checks++; if (c_bad !== 0) begin $display("FAIL random_pulse_rules%0d got %0d want 0", n, c_bad); n_fail++; end
        end
        two_stop = 1'b0;
        parity_mode = 2'd0;
        prescale = 16'd2;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_glitch();
        test_break();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
